avalon_mem_slave: RTL and testbench

Avalon-MM slave memory that sits directly downstream of the CPU's bus master port. It services word reads and byte-enabled writes to an internal word array mapped at a base address, and inserts a programmable number of wait states through waitrequest. A side-band load port lets the bench preload program images before the CPU leaves reset. It is the memory the top-level bench instantiates against the CPU's address/read/write/writedata/byteenable/readdata/waitrequest pins.

---
 rtl/avalon_mem_slave.sv | 117 +++++++++++
 tb/tb_avalon_mem_slave.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_mem_slave.sv
// Avalon-MM slave word memory with programmable wait states.
// Side-band load port preloads program images.
module avalon_mem_slave #(
    parameter int          ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           address,
    input  logic                  read,
    input  logic                  write,
    input  logic [31:0]           writedata,
    input  logic [3:0]            byteenable,
    output logic                  waitrequest,
    output logic [31:0]           readdata,
    output logic                  err,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [31:0]           load_data
);

    localparam int          DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [32:0] OFF_LIMIT = 33'(4) << ADDR_WIDTH;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] ACK  = 2'd2;

    logic [1:0]            state;
    logic [3:0]            cnt;
    logic [31:0]           addr_q;
    logic [31:0]           wdata_q;
    logic [3:0]            be_q;
    logic                  wr_q;
    logic [31:0]           mem [DEPTH];

    logic                  req;
    logic [31:0]           offset;
    logic                  in_range;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  commit;
    logic                  commit_wr;

    assign req       = read | write;
    assign offset    = addr_q - BASE_ADDR;
    assign in_range  = {1'b0, offset} < OFF_LIMIT;
    assign idx       = offset[ADDR_WIDTH+1:2];
    assign commit    = reset && (state == BUSY) && req && (cnt == 4'd0);
    assign commit_wr = commit && wr_q && in_range;

    always_comb begin
        waitrequest = 1'b1;
        if (reset) begin
            unique case (state)
                IDLE:    waitrequest = req;
                BUSY:    waitrequest = 1'b1;
                ACK:     waitrequest = 1'b0;
                default: waitrequest = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            readdata <= 32'd0;
            err      <= 1'b0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            be_q     <= 4'd0;
            wr_q     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req) begin
                        addr_q  <= address;
                        wr_q    <= write & ~read;
                        wdata_q <= writedata;
                        be_q    <= byteenable;
                        cnt     <= WAIT_INIT;
                        state   <= BUSY;
                        if (read && write) err <= 1'b1;
                    end
                end
                BUSY: begin
                    // Master abandoned the transfer: no commit.
                    if (!req) begin
                        state <= IDLE;
                        err   <= 1'b1;
                    end else if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (!wr_q) readdata <= in_range ? mem[idx] : 32'd0;
                        if (!in_range) err <= 1'b1;
                        state <= ACK;
                    end
                end
                ACK:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Bus bytes are assigned after the load word so they win on collision.
    always_ff @(posedge clk) begin
        if (load_en) mem[load_addr] <= load_data;
        if (commit_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_avalon_mem_slave.sv
// Randomized bench for avalon_mem_slave, two instances
// (2 and 0 wait states) against a word-array reference model.
module tb_avalon_mem_slave;

    localparam logic [31:0] BASE = 32'hBFC00000;
    localparam int WC [2] = '{2, 0};

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] address [2];
    logic        read [2];
    logic        write [2];
    logic [31:0] writedata [2];
    logic [3:0]  byteenable [2];
    logic        waitrequest [2];
    logic [31:0] readdata [2];
    logic        err [2];
    logic        load_en [2];
    logic [9:0]  load_addr [2];
    logic [31:0] load_data [2];

    int total = 0;
    int bad = 0;

    logic [31:0] mem_m [2][1024];
    logic        err_m [2];
    logic [31:0] last_rd [2];

    always #5 clk = ~clk;

    avalon_mem_slave #(
        .ADDR_WIDTH(10), .BASE_ADDR(BASE), .WAIT_CYCLES(2)
    ) u_dut2 (
        .clk(clk), .reset(reset),
        .address(address[0]), .read(read[0]), .write(write[0]),
        .writedata(writedata[0]), .byteenable(byteenable[0]),
        .waitrequest(waitrequest[0]), .readdata(readdata[0]),
        .err(err[0]), .load_en(load_en[0]),
        .load_addr(load_addr[0]), .load_data(load_data[0])
    );

    avalon_mem_slave #(
        .ADDR_WIDTH(10), .BASE_ADDR(BASE), .WAIT_CYCLES(0)
    ) u_dut0 (
        .clk(clk), .reset(reset),
        .address(address[1]), .read(read[1]), .write(write[1]),
        .writedata(writedata[1]), .byteenable(byteenable[1]),
        .waitrequest(waitrequest[1]), .readdata(readdata[1]),
        .err(err[1]), .load_en(load_en[1]),
        .load_addr(load_addr[1]), .load_data(load_data[1])
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic load(input int d, input int a, input logic [31:0] v);
        @(negedge clk);
        load_en[d] = 1'b1;
        load_addr[d] = 10'(a);
        load_data[d] = v;
        mem_m[d][a] = v;
        @(negedge clk);
        load_en[d] = 1'b0;
    endtask

    task automatic xfer(input int d, input bit rd, input bit wr,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, input bit ld,
                        input int la, input logic [31:0] ldd,
                        output logic [31:0] rdata);
        int k;
        logic [31:0] off;
        bit inr;
        int w;
        @(negedge clk);
        address[d] = a;
        read[d] = rd;
        write[d] = wr;
        writedata[d] = wd;
        byteenable[d] = be;
        k = 0;
        #1;
        while (waitrequest[d] && k < 40) begin
            if (ld && k == WC[d] + 1) begin
                load_en[d] = 1'b1;
                load_addr[d] = 10'(la);
                load_data[d] = ldd;
            end
            @(negedge clk);
            load_en[d] = 1'b0;
            k++;
            #1;
        end
        check($sformatf("lat%0d", d), 32'(k), 32'(WC[d] + 2));
        off = a - BASE;
        inr = off < 32'd4096;
        w = int'(off >> 2);
        if (rd) last_rd[d] = inr ? mem_m[d][w] : 32'd0;
        if (ld) mem_m[d][la] = ldd;
        if (wr && !rd && inr) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mem_m[d][w][8*b +: 8] = wd[8*b +: 8];
        end
        if (!inr || (rd && wr)) err_m[d] = 1'b1;
        rdata = readdata[d];
        check($sformatf("rdata%0d", d), readdata[d], last_rd[d]);
        check($sformatf("err%0d", d), 32'(err[d]), 32'(err_m[d]));
        read[d] = 1'b0;
        write[d] = 1'b0;
    endtask

    task automatic rd_word(input int d, input logic [31:0] a,
                           output logic [31:0] v);
        xfer(d, 1'b1, 1'b0, a, 32'd0, 4'h0, 1'b0, 0, 32'd0, v);
    endtask

    task automatic wr_word(input int d, input logic [31:0] a,
                           input logic [31:0] v, input logic [3:0] be);
        logic [31:0] t;
        xfer(d, 1'b0, 1'b1, a, v, be, 1'b0, 0, 32'd0, t);
    endtask

    task automatic abort_rd(input int d, input logic [31:0] a);
        logic [31:0] t;
        @(negedge clk);
        address[d] = a;
        read[d] = 1'b1;
        @(negedge clk);
        read[d] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        err_m[d] = 1'b1;
        check($sformatf("abort_err%0d", d), 32'(err[d]), 32'd1);
        check($sformatf("abort_rd%0d", d), readdata[d], last_rd[d]);
        rd_word(d, a + 32'd4, t);
    endtask

    initial begin
        logic [31:0] v;
        int d;
        int r;
        logic [31:0] a;
        for (int i = 0; i < 2; i++) begin
            address[i] = '0; read[i] = 0; write[i] = 0;
            writedata[i] = '0; byteenable[i] = '0;
            load_en[i] = 0; load_addr[i] = '0; load_data[i] = '0;
            err_m[i] = 0; last_rd[i] = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_wait", 32'(waitrequest[i]), 32'd1);
            check("rst_rdata", readdata[i], 32'd0);
            check("rst_err", 32'(err[i]), 32'd0);
        end
        reset = 1'b1;

        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            for (int j = 0; j < 2; j++) begin
                load_en[j] = 1'b1;
                load_addr[j] = 10'(i);
                load_data[j] = $urandom;
                mem_m[j][i] = load_data[j];
            end
        end
        @(negedge clk);
        load_en[0] = 1'b0;
        load_en[1] = 1'b0;

        wr_word(0, BASE + 32'd4, 32'h11223344, 4'hF);
        rd_word(0, BASE + 32'd4, v);
        check("tp_wr_rd", v, 32'h11223344);
        wr_word(0, BASE + 32'd4, 32'hAABBCCDD, 4'b0010);
        rd_word(0, BASE + 32'd4, v);
        check("tp_be", v, 32'h1122CC44);
        wr_word(0, BASE + 32'd4, 32'h55667788, 4'b0000);
        rd_word(0, BASE + 32'd6, v);
        check("tp_be0", v, 32'h1122CC44);
        check("tp_be0_err", 32'(err[0]), 32'd0);
        wr_word(0, BASE + 32'hFFC, 32'hCAFEF00D, 4'hF);
        rd_word(0, BASE + 32'hFFC, v);
        check("tp_last", v, 32'hCAFEF00D);

        rd_word(0, 32'h00000000, v);
        check("tp_oor_rd", v, 32'd0);
        check("tp_oor_err", 32'(err[0]), 32'd1);
        wr_word(0, BASE + 32'h1000, 32'h99999999, 4'hF);
        rd_word(0, BASE + 32'd4, v);
        check("tp_oor_wr", v, 32'h1122CC44);

        load(0, 0, 32'h3C020005);
        rd_word(0, BASE, v);
        check("tp_load", v, 32'h3C020005);
        xfer(0, 1'b0, 1'b1, BASE, 32'h0, 4'b0001,
             1'b1, 0, 32'hFFFFFFFF, v);
        rd_word(0, BASE, v);
        check("tp_collide", v, 32'hFFFFFF00);
        xfer(1, 1'b0, 1'b1, BASE + 32'd8, 32'h0000AB00, 4'b0010,
             1'b1, 2, 32'h76543210, v);
        rd_word(1, BASE + 32'd8, v);
        check("tp_collide0", v, 32'h7654AB10);

        load(0, 5, 32'h12345678);
        @(negedge clk);
        address[0] = BASE + 32'd20;
        write[0] = 1'b1;
        writedata[0] = 32'hDEADBEEF;
        byteenable[0] = 4'hF;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_busy_wait", 32'(waitrequest[0]), 32'd1);
        check("rst_busy_rdata", readdata[0], 32'd0);
        check("rst_busy_err", 32'(err[0]), 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("rst_hold_wait", 32'(waitrequest[0]), 32'd1);
        write[0] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            err_m[i] = 1'b0;
            last_rd[i] = '0;
        end
        rd_word(0, BASE + 32'd20, v);
        check("rst_discard", v, 32'h12345678);

        abort_rd(0, BASE + 32'd40);
        abort_rd(1, BASE + 32'd40);

        for (int i = 0; i < 8; i++) rd_word(1, BASE + 32'(4 * i), v);

        for (int n = 0; n < 200; n++) begin
            d = $urandom_range(0, 1);
            r = $urandom_range(0, 9);
            if ($urandom_range(0, 7) == 0) a = $urandom;
            else a = BASE + 32'($urandom_range(0, 4095));
            xfer(d, (r < 4) || (r >= 8), (r >= 4) && (r <= 8), a,
                 $urandom, 4'($urandom),
                 $urandom_range(0, 5) == 0,
                 ($urandom_range(0, 1) == 0) ?
                     int'(((a - BASE) >> 2) & 32'h3FF) :
                     $urandom_range(0, 1023),
                 $urandom, v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
